// File: rtl/gf251_pkg.sv
// Shared constants for the GF(251) word multiplier and the logic around it.
// A word is four independent byte lanes, each holding one field element.
package gf251_pkg;

    localparam int W_WORD = 32;
    localparam int LANE_W = 8;
    localparam int GF_P   = 251;

    // Width needed to index n items, never less than one bit
    function automatic int tagWidth(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active request at or after
// the rotating pointer. The pointer moves just past the winner on every grant
// and holds otherwise. While reset is high no grant is given.
module rr_arbiter
    import gf251_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = tagWidth(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_grant_valid
);

    localparam int CW = IW + 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cand;
    logic          found;

    // Scan requesters starting at the pointer, wrapping at N, keep the first hit
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && !i_rst && i_req[cand[IW-1:0]]) begin
                found                 = 1'b1;
                o_grant[cand[IW-1:0]] = 1'b1;
                o_grant_idx           = cand[IW-1:0];
            end
        end
    end

    assign o_grant_valid = found;

    // Advance the pointer one past the winner so every requester gets a turn
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (o_grant_idx == IW'(N - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

    // Pointer register, returns to requester 0 on reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gf251_mul_arbiter.sv
// Shares one external GF(251) word multiplier between N_REQ requesters.
// A granted operand pair is registered into the multiplier the next cycle,
// its requester index rides a tag pipeline matching the multiplier latency,
// and the returning product is registered and steered to that requester.
// After reset a drain window masks stray done pulses from discarded work.
module gf251_mul_arbiter
    import gf251_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int MUL_LAT = 3,
    parameter int W       = W_WORD
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [N_REQ*W-1:0] i_req_x,
    input  logic [N_REQ*W-1:0] i_req_y,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [N_REQ-1:0]   o_res_valid,
    output logic [W-1:0]       o_res,
    output logic               o_mul_start,
    output logic [W-1:0]       o_mul_x,
    output logic [W-1:0]       o_mul_y,
    input  logic [W-1:0]       i_mul_o,
    input  logic               i_mul_done,
    output logic               o_busy,
    output logic               o_err
);

    localparam int IW = tagWidth(N_REQ);
    localparam int DW = tagWidth(MUL_LAT + 1);

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grantIdx;
    logic             grantValid;
    logic [W-1:0]     selX, selY;

    logic                          issueValid_q, issueValid_d;
    logic [IW-1:0]                 issueIdx_q, issueIdx_d;
    logic [W-1:0]                  mulX_q, mulX_d;
    logic [W-1:0]                  mulY_q, mulY_d;
    logic [MUL_LAT-1:0]            tagValid_q, tagValid_d;
    logic [MUL_LAT-1:0][IW-1:0]    tagIdx_q, tagIdx_d;
    logic [N_REQ-1:0]              resValid_q, resValid_d;
    logic [W-1:0]                  res_q, res_d;
    logic                          err_q, err_d;
    logic [DW-1:0]                 drain_q, drain_d;

    logic          tailValid;
    logic [IW-1:0] tailIdx;
    logic          resHit;
    logic          mismatch;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req_valid),
        .o_grant       (grant),
        .o_grant_idx   (grantIdx),
        .o_grant_valid (grantValid)
    );

    // Operand mux driven by the one-hot grant
    always_comb begin
        selX = '0;
        selY = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                selX = i_req_x[k*W +: W];
                selY = i_req_y[k*W +: W];
            end
        end
    end

    assign tailValid = tagValid_q[MUL_LAT-1];
    assign tailIdx   = tagIdx_q[MUL_LAT-1];
    assign resHit    = i_mul_done && tailValid;
    assign mismatch  = (i_mul_done != tailValid);

    // Next state for issue, tag pipeline, result steering, error and drain
    always_comb begin
        issueValid_d = grantValid;
        issueIdx_d   = grantValid ? grantIdx : issueIdx_q;
        mulX_d       = grantValid ? selX : mulX_q;
        mulY_d       = grantValid ? selY : mulY_q;

        tagValid_d    = '0;
        tagIdx_d      = '0;
        tagValid_d[0] = issueValid_q;
        tagIdx_d[0]   = issueIdx_q;
        for (int s = 1; s < MUL_LAT; s++) begin
            tagValid_d[s] = tagValid_q[s-1];
            tagIdx_d[s]   = tagIdx_q[s-1];
        end

        resValid_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            resValid_d[k] = resHit && (tailIdx == IW'(k));
        end
        res_d = resHit ? i_mul_o : res_q;

        err_d   = err_q | (mismatch && (drain_q == '0));
        drain_d = (drain_q != '0) ? drain_q - 1'b1 : drain_q;
    end

    // State registers; reset discards in-flight work and reopens the drain window
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            issueValid_q <= 1'b0;
            issueIdx_q   <= '0;
            mulX_q       <= '0;
            mulY_q       <= '0;
            tagValid_q   <= '0;
            tagIdx_q     <= '0;
            resValid_q   <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            drain_q      <= DW'(MUL_LAT);
        end else begin
            issueValid_q <= issueValid_d;
            issueIdx_q   <= issueIdx_d;
            mulX_q       <= mulX_d;
            mulY_q       <= mulY_d;
            tagValid_q   <= tagValid_d;
            tagIdx_q     <= tagIdx_d;
            resValid_q   <= resValid_d;
            res_q        <= res_d;
            err_q        <= err_d;
            drain_q      <= drain_d;
        end
    end

    assign o_req_ready = grant;
    assign o_mul_start = issueValid_q;
    assign o_mul_x     = mulX_q;
    assign o_mul_y     = mulY_q;
    assign o_res_valid = resValid_q;
    assign o_res       = res_q;
    assign o_err       = err_q;
    assign o_busy      = (|tagValid_q) | issueValid_q | (|resValid_q);

endmodule

// File: doc/gf251_mul_arbiter.md
Name: gf251_mul_arbiter

Overview:
- Round-robin scheduler that shares one gf251_mul_32 instance (four GF(251) byte lanes per 32-bit word, fixed pipeline latency) between N_REQ requesters.
- Accepts operand pairs from requesters with a valid/ready handshake and issues at most one multiply per cycle.
- Tracks the requester of each in-flight operation in a tag pipeline and steers each result back to its requester.
- Sits between the SDitH arithmetic engines and the shared multiplier; the multiplier is instantiated outside this block.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- MUL_LAT, 3, cycles from multiplier i_start to o_done; must match the multiplier instance.
- W, 32, operand/result width (4 lanes x 8 bits).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  N_REQ  requester k has an operand pair
- i_req_x  in  N_REQ*W  operand x, requester k at bits [k*W +: W]
- i_req_y  in  N_REQ*W  operand y, same packing
- o_req_ready  out  N_REQ  one-hot grant; handshake when valid & ready
- o_res_valid  out  N_REQ  one-hot result strobe for requester k
- o_res  out  W  result word, valid when any o_res_valid bit is set
- o_mul_start  out  1  to multiplier i_start
- o_mul_x  out  W  to multiplier i_x
- o_mul_y  out  W  to multiplier i_y
- i_mul_o  in  W  from multiplier o_o
- i_mul_done  in  1  from multiplier o_done
- o_busy  out  1  operations in flight or pending issue
- o_err  out  1  sticky: i_mul_done disagreed with tag pipeline

Behaviour:
- Reset: all outputs 0, tag pipeline cleared, RR pointer = 0, drain counter = MUL_LAT.
- Grant (combinational): o_req_ready is one-hot, selecting the first valid requester at or after the RR pointer. It is all-zero when i_req_valid = 0 or i_rst = 1.
- On handshake with requester g: pointer <= (g+1) mod N_REQ. The pointer holds when there is no handshake.
- Issue register, one cycle after handshake: o_mul_start = 1, o_mul_x/o_mul_y = operands of g. Otherwise o_mul_start = 0 and o_mul_x/o_mul_y hold their last value.
- Tag pipeline: MUL_LAT stages of {valid, idx[clog2(N_REQ)]}, pushed together with o_mul_start.
- The tail stage aligns with i_mul_done.
- Result register: when i_mul_done = 1 and tail.valid = 1, then next cycle o_res = i_mul_o and o_res_valid[tail.idx] = 1. Otherwise o_res_valid = 0.
- Total latency from handshake edge to o_res_valid: MUL_LAT + 2 cycles.
- Throughput: one op/cycle sustained. There is no backpressure on results; requesters must always accept o_res_valid.
- Fairness: with all N_REQ valid continuously, grants rotate 0,1,..,N_REQ-1,0,...
- A single valid requester gets a grant every cycle.
- Error: when i_mul_done != tail.valid, set o_err = 1 (sticky until i_rst), and suppress o_res_valid for that cycle.
- Error exemption: the check is disabled while the drain counter is nonzero.
- Reset mid-operation: in-flight ops are discarded. Their late i_mul_done pulses fall in the drain window and are ignored, with no error and no result.
- Drain window: the drain counter decrements each cycle after reset deasserts. Grants are allowed during the drain window.
- o_busy = any tag stage valid OR issue register valid OR result register valid.
- Operands are passed through unchecked; lane values >= 251 are the requester's responsibility.

Decomposition:
- Shared package gf251_pkg: W_WORD=32, LANE_W=8, GF_P=251, and localparam function for clog2 tag width.
- Sub-module rr_arbiter: N_REQ-wide round-robin one-hot grant with pointer update. It is reused elsewhere in the codebase.
- The tag pipeline, issue register and result steering stay in the top module.

Test Plan:
- Single request: after reset, req0 presents x=0x22222222, y=0x44444444 -> one grant. o_mul_start rises 1 cycle later. o_res_valid[0] rises MUL_LAT+2 cycles after handshake with o_res=0x35353535; o_err=0.
- Contention: req0 (0x01020304 x 0x05060708) and req1 (0x22222222 x 0x44444444) are valid simultaneously and held for 4 handshakes -> grants 0,1,0,1. Results alternate o_res_valid[0] with 0x050c1520 and [1] with 0x35353535, back-to-back with no gaps.
- Pointer wrap: N_REQ=3, all valid for 7 cycles -> grant sequence 0,1,2,0,1,2,0.
- Reset mid-flight: issue 3 back-to-back ops, assert i_rst for 1 cycle while they are in the pipeline -> no o_res_valid from those ops, o_err stays 0, o_busy=0 the cycle after reset. A new request after reset completes correctly.
- Misaligned done: the bench model of the multiplier delays o_done by MUL_LAT+1 -> o_err goes to 1 at the first mismatch and stays 1; no o_res_valid is asserted on the mismatched cycle.
- Idle: no valid for 20 cycles -> o_req_ready=0, o_mul_start=0, o_res_valid=0, o_busy=0 throughout.
